// File: rtl/atm_pkg.sv
// Shared definitions for the ATM HEC checker: FSM state encoding,
// HEC coset, cell geometry and the CRC-8 header checksum function.
package atm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_HEC = 2'd1,
    PAYLOAD  = 2'd2,
    DISCARD  = 2'd3
  } state_t;

  localparam logic [7:0]  HEC_COSET          = 8'h55;
  localparam int unsigned CELL_PAYLOAD_BEATS = 12;

  // CRC-8, polynomial x^8+x^2+x+1, init 0, MSB first, no reflection.
  // The coset is applied by the caller.
  function automatic logic [7:0] crc8_32(input logic [31:0] data);
    logic [7:0] crc;
    crc = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (crc[7] ^ data[31 - i])
        crc = {crc[6:0], 1'b0} ^ 8'h07;
      else
        crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/atm_hec_syndrome_decode.sv
// Maps an 8-bit HEC syndrome onto a one-hot 40-bit error position.
// Bits [39:8] flag a header bit (bit i+8 = header word bit i),
// bits [7:0] flag a bit of the received HEC byte. All zero when the
// syndrome does not match any single-bit error.
module atm_hec_syndrome_decode
  import atm_pkg::*;
(
  input  logic [7:0]  syndrome,
  output logic [39:0] err_pos
);

  // Compare the syndrome against every single-bit error signature.
  always_comb begin
    err_pos = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (syndrome == 8'(1 << i))
        err_pos[i] = 1'b1;
    end
    for (int unsigned i = 0; i < 32; i++) begin
      if (syndrome == crc8_32(32'h1 << i))
        err_pos[i + 8] = 1'b1;
    end
  end

endmodule

// File: rtl/atm_hec_checker.sv
// ATM cell HEC checker. Checks the header HEC of each fixed-format cell,
// forwards good cells with one cycle of latency, drops or forwards bad
// ones depending on DROP_BAD, and keeps saturating statistics.
// Optional build macro ATM_HEC_CORRECT_EN enables single-bit correction.
module atm_hec_checker
  import atm_pkg::*;
#(
  parameter int unsigned DROP_BAD  = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic                 din_start,
  input  logic [2:0]           din_len,
  input  logic [31:0]          din,
  output logic                 dout_valid,
  output logic                 dout_start,
  output logic                 dout_end,
  output logic [31:0]          dout,
  output logic                 hdr_ok,
  output logic                 hdr_corrected,
  output logic [CNT_WIDTH-1:0] cnt_good,
  output logic [CNT_WIDTH-1:0] cnt_corrected,
  output logic [CNT_WIDTH-1:0] cnt_bad,
  output logic [CNT_WIDTH-1:0] cnt_framing
);

  state_t      state, state_nxt;
  logic [3:0]  beat_cnt, beat_nxt;
  logic [31:0] hdr_q, hdr_nxt;
  logic [7:0]  syndrome;
  logic        last_beat;
  logic        restart;

  logic        o_valid, o_start, o_end, o_ok;
  logic [31:0] o_data;
  logic        inc_good, inc_corr, inc_bad, inc_framing;

  assign syndrome  = crc8_32(hdr_q) ^ HEC_COSET ^ din[31:24];
  assign last_beat = (beat_cnt == 4'(CELL_PAYLOAD_BEATS - 1));

`ifdef ATM_HEC_CORRECT_EN
  logic [39:0] err_pos;
  logic        o_corr;

  atm_hec_syndrome_decode u_syndrome_decode (
    .syndrome (syndrome),
    .err_pos  (err_pos)
  );
`else
  assign hdr_corrected = 1'b0;
`endif

  // Next-state, output-beat and counter-increment decisions for one beat.
  // An abort caused by a start beat falls through to the IDLE header
  // check in the same cycle via 'restart'.
  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat_cnt;
    hdr_nxt     = hdr_q;
    restart     = 1'b0;
    o_valid     = 1'b0;
    o_start     = 1'b0;
    o_end       = 1'b0;
    o_ok        = 1'b0;
    o_data      = '0;
    inc_good    = 1'b0;
    inc_corr    = 1'b0;
    inc_bad     = 1'b0;
    inc_framing = 1'b0;
`ifdef ATM_HEC_CORRECT_EN
    o_corr      = 1'b0;
`endif
    if (din_valid) begin
      case (state)
        IDLE: restart = 1'b1;
        WAIT_HEC: begin
          if (din_start) begin
            inc_framing = 1'b1;
            restart     = 1'b1;
          end else if (din_len != 3'd1) begin
            inc_framing = 1'b1;
            state_nxt   = IDLE;
          end else if (syndrome == '0) begin
            o_valid   = 1'b1;
            o_start   = 1'b1;
            o_ok      = 1'b1;
            o_data    = hdr_q;
            inc_good  = 1'b1;
            state_nxt = PAYLOAD;
            beat_nxt  = '0;
          end
`ifdef ATM_HEC_CORRECT_EN
          else if (|err_pos) begin
            o_valid   = 1'b1;
            o_start   = 1'b1;
            o_ok      = 1'b1;
            o_corr    = 1'b1;
            o_data    = hdr_q ^ err_pos[39:8];
            inc_corr  = |err_pos[39:8];
            state_nxt = PAYLOAD;
            beat_nxt  = '0;
          end
`endif
          else begin
            inc_bad  = 1'b1;
            beat_nxt = '0;
            if (DROP_BAD == 0) begin
              o_valid   = 1'b1;
              o_start   = 1'b1;
              o_data    = hdr_q;
              state_nxt = PAYLOAD;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end
        PAYLOAD: begin
          if (din_start || din_len != 3'd4) begin
            inc_framing = 1'b1;
            o_valid     = 1'b1;
            o_end       = 1'b1;
            state_nxt   = IDLE;
            restart     = din_start;
          end else begin
            o_valid = 1'b1;
            o_data  = din;
            if (last_beat) begin
              o_end     = 1'b1;
              state_nxt = IDLE;
            end else begin
              beat_nxt = beat_cnt + 4'd1;
            end
          end
        end
        DISCARD: begin
          if (din_start || din_len != 3'd4) begin
            inc_framing = 1'b1;
            state_nxt   = IDLE;
            restart     = din_start;
          end else if (last_beat) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (restart) begin
        if (din_start && din_len == 3'd4) begin
          hdr_nxt   = din;
          state_nxt = WAIT_HEC;
        end else begin
          state_nxt = IDLE;
          if (state == IDLE)
            inc_framing = 1'b1;
        end
      end
    end
  end

  // State, header register and registered output beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      hdr_q      <= '0;
      dout_valid <= 1'b0;
      dout_start <= 1'b0;
      dout_end   <= 1'b0;
      hdr_ok     <= 1'b0;
      dout       <= '0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_nxt;
      hdr_q      <= hdr_nxt;
      dout_valid <= o_valid;
      dout_start <= o_start;
      dout_end   <= o_end;
      hdr_ok     <= o_ok;
      dout       <= o_data;
    end
  end

`ifdef ATM_HEC_CORRECT_EN
  // Corrected-header flag, aligned with the header output beat.
  always_ff @(posedge clk) begin
    if (!rst_n)
      hdr_corrected <= 1'b0;
    else
      hdr_corrected <= o_corr;
  end
`endif

  // Saturating statistics counters; each updates independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_good      <= '0;
      cnt_corrected <= '0;
      cnt_bad       <= '0;
      cnt_framing   <= '0;
    end else begin
      if (inc_good && cnt_good != '1)
        cnt_good <= cnt_good + 1'b1;
      if (inc_corr && cnt_corrected != '1)
        cnt_corrected <= cnt_corrected + 1'b1;
      if (inc_bad && cnt_bad != '1)
        cnt_bad <= cnt_bad + 1'b1;
      if (inc_framing && cnt_framing != '1)
        cnt_framing <= cnt_framing + 1'b1;
    end
  end

endmodule

// File: tb/tb_atm_hec_checker.sv
// Directed testbench for atm_hec_checker. Counters are built 3 bits wide
// so saturation is reachable with a handful of cells.
// Hand-computed HECs: hdr 0->0x55, hdr 1->0x52, hdr 2->0x5B.
module tb_atm_hec_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_valid, din_start;
  logic [2:0]  din_len;
  logic [31:0] din;
  logic        dout_valid, dout_start, dout_end, hdr_ok, hdr_corrected;
  logic [31:0] dout;
  logic [2:0]  cnt_good, cnt_corrected, cnt_bad, cnt_framing;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  atm_hec_checker #(.DROP_BAD(1), .CNT_WIDTH(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .din_valid     (din_valid),
    .din_start     (din_start),
    .din_len       (din_len),
    .din           (din),
    .dout_valid    (dout_valid),
    .dout_start    (dout_start),
    .dout_end      (dout_end),
    .dout          (dout),
    .hdr_ok        (hdr_ok),
    .hdr_corrected (hdr_corrected),
    .cnt_good      (cnt_good),
    .cnt_corrected (cnt_corrected),
    .cnt_bad       (cnt_bad),
    .cnt_framing   (cnt_framing)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input at a falling edge; outputs for it are
  // visible at the next falling edge, where this task returns.
  task automatic step(input logic v, input logic s, input logic [2:0] l,
                      input logic [31:0] d);
    din_valid = v;
    din_start = s;
    din_len   = l;
    din       = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 3'd0, '0);
    step(1'b0, 1'b0, 3'd0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF);
    nvec++;
    if ({dout_valid, dout_start, dout_end, hdr_ok, hdr_corrected} !== 5'b0 || dout !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: flags=%b dout=%h, want 00000 / 00000000",
               {dout_valid, dout_start, dout_end, hdr_ok, hdr_corrected}, dout);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if ({cnt_good, cnt_corrected, cnt_bad, cnt_framing} !== 12'b0 || dout_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_counters: cnts=%h valid=%b, want 000 / 0",
               {cnt_good, cnt_corrected, cnt_bad, cnt_framing}, dout_valid);
    end
  endtask

  task automatic test_good_cell();
    do_reset();
    step(1'b1, 1'b1, 3'd4, 32'h0000_0001);
    nvec++;
    if (dout_valid !== 1'b0) begin
      nerr++;
      $display("FAIL good_hdr_beat: valid=%b, want 0", dout_valid);
    end
    step(1'b1, 1'b0, 3'd1, 32'h5200_0000);
    nvec++;
    if (dout_valid !== 1'b1 || dout_start !== 1'b1 || hdr_ok !== 1'b1 || hdr_corrected !== 1'b0 ||
        dout_end !== 1'b0 || dout !== 32'h0000_0001) begin
      nerr++;
      $display("FAIL good_hdr_out: v=%b s=%b ok=%b c=%b e=%b d=%h, want 1 1 1 0 0 00000001",
               dout_valid, dout_start, hdr_ok, hdr_corrected, dout_end, dout);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 3'd4, 32'hA000_0000 + i);
      nvec++;
      if (dout_valid !== 1'b1 || dout_start !== 1'b0 || dout_end !== (i == 11) ||
          dout !== 32'hA000_0000 + i) begin
        nerr++;
        $display("FAIL good_payload[%0d]: v=%b s=%b e=%b d=%h, want 1 0 %b %h",
                 i, dout_valid, dout_start, dout_end, dout, i == 11, 32'hA000_0000 + i);
      end
    end
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if (dout_valid !== 1'b0 || cnt_good !== 3'd1 || cnt_bad !== 3'd0 || cnt_framing !== 3'd0) begin
      nerr++;
      $display("FAIL good_counts: v=%b good=%0d bad=%0d fr=%0d, want 0 1 0 0",
               dout_valid, cnt_good, cnt_bad, cnt_framing);
    end
  endtask

  task automatic test_hec_error();
    do_reset();
    step(1'b1, 1'b1, 3'd4, 32'h0000_0000);
    step(1'b1, 1'b0, 3'd1, 32'h5200_0000);
`ifdef ATM_HEC_CORRECT_EN
    nvec++;
    if (dout_valid !== 1'b1 || hdr_ok !== 1'b1 || hdr_corrected !== 1'b1 || dout !== 32'h0000_0001) begin
      nerr++;
      $display("FAIL corr_hdr: v=%b ok=%b c=%b d=%h, want 1 1 1 00000001",
               dout_valid, hdr_ok, hdr_corrected, dout);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 3'd4, 32'hB000_0000 + i);
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if (cnt_corrected !== 3'd1 || cnt_bad !== 3'd0) begin
      nerr++;
      $display("FAIL corr_counts: corr=%0d bad=%0d, want 1 0", cnt_corrected, cnt_bad);
    end
`else
    nvec++;
    if (dout_valid !== 1'b0 || hdr_corrected !== 1'b0) begin
      nerr++;
      $display("FAIL syn07_hdr: v=%b c=%b, want 0 0", dout_valid, hdr_corrected);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 3'd4, 32'hB000_0000 + i);
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if (cnt_bad !== 3'd1 || cnt_corrected !== 3'd0 || cnt_good !== 3'd0) begin
      nerr++;
      $display("FAIL syn07_counts: bad=%0d corr=%0d good=%0d, want 1 0 0",
               cnt_bad, cnt_corrected, cnt_good);
    end
`endif
  endtask

  task automatic test_bad_drop();
    int unsigned seen;
    do_reset();
    seen = 0;
    step(1'b1, 1'b1, 3'd4, 32'h0000_0000);
    if (dout_valid) seen++;
    step(1'b1, 1'b0, 3'd1, 32'hAA00_0000);
    if (dout_valid) seen++;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 3'd4, 32'hC000_0000 + i);
      if (dout_valid) seen++;
    end
    nvec++;
    if (seen != 0 || cnt_bad !== 3'd1 || cnt_framing !== 3'd0) begin
      nerr++;
      $display("FAIL drop_bad: out_beats=%0d bad=%0d fr=%0d, want 0 1 0", seen, cnt_bad, cnt_framing);
    end
    step(1'b1, 1'b1, 3'd4, 32'h0000_0002);
    step(1'b1, 1'b0, 3'd1, 32'h5B00_0000);
    nvec++;
    if (dout_valid !== 1'b1 || dout_start !== 1'b1 || hdr_ok !== 1'b1 || dout !== 32'h0000_0002) begin
      nerr++;
      $display("FAIL drop_next_hdr: v=%b s=%b ok=%b d=%h, want 1 1 1 00000002",
               dout_valid, dout_start, hdr_ok, dout);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 3'd4, 32'hD000_0000 + i);
      nvec++;
      if (dout_valid !== 1'b1 || dout_end !== (i == 11) || dout !== 32'hD000_0000 + i) begin
        nerr++;
        $display("FAIL drop_next_payload[%0d]: v=%b e=%b d=%h, want 1 %b %h",
                 i, dout_valid, dout_end, dout, i == 11, 32'hD000_0000 + i);
      end
    end
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if (cnt_good !== 3'd1 || cnt_bad !== 3'd1) begin
      nerr++;
      $display("FAIL drop_counts: good=%0d bad=%0d, want 1 1", cnt_good, cnt_bad);
    end
  endtask

  task automatic test_framing_restart();
    do_reset();
    step(1'b1, 1'b1, 3'd4, 32'h0000_0001);
    step(1'b1, 1'b0, 3'd1, 32'h5200_0000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd4, 32'hE000_0000 + i);
    step(1'b1, 1'b1, 3'd4, 32'h0000_0002);
    nvec++;
    if (dout_valid !== 1'b1 || dout_end !== 1'b1 || dout_start !== 1'b0 || cnt_framing !== 3'd1) begin
      nerr++;
      $display("FAIL restart_abort: v=%b e=%b s=%b fr=%0d, want 1 1 0 1",
               dout_valid, dout_end, dout_start, cnt_framing);
    end
    step(1'b1, 1'b0, 3'd1, 32'h5B00_0000);
    nvec++;
    if (dout_valid !== 1'b1 || dout_start !== 1'b1 || hdr_ok !== 1'b1 || dout !== 32'h0000_0002) begin
      nerr++;
      $display("FAIL restart_hdr: v=%b s=%b ok=%b d=%h, want 1 1 1 00000002",
               dout_valid, dout_start, hdr_ok, dout);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 3'd4, 32'hF000_0000 + i);
      nvec++;
      if (dout_valid !== 1'b1 || dout_end !== (i == 11) || dout !== 32'hF000_0000 + i) begin
        nerr++;
        $display("FAIL restart_payload[%0d]: v=%b e=%b d=%h, want 1 %b %h",
                 i, dout_valid, dout_end, dout, i == 11, 32'hF000_0000 + i);
      end
    end
    step(1'b0, 1'b0, 3'd0, '0);
    nvec++;
    if (cnt_good !== 3'd2 || cnt_framing !== 3'd1) begin
      nerr++;
      $display("FAIL restart_counts: good=%0d fr=%0d, want 2 1", cnt_good, cnt_framing);
    end
  endtask

  task automatic test_framing_len();
    do_reset();
    step(1'b1, 1'b1, 3'd4, 32'h0000_0001);
    step(1'b1, 1'b0, 3'd4, 32'h5200_0000);
    nvec++;
    if (dout_valid !== 1'b0 || cnt_framing !== 3'd1) begin
      nerr++;
      $display("FAIL hec_len: v=%b fr=%0d, want 0 1", dout_valid, cnt_framing);
    end
    step(1'b1, 1'b0, 3'd4, 32'h1234_5678);
    nvec++;
    if (dout_valid !== 1'b0 || cnt_framing !== 3'd2) begin
      nerr++;
      $display("FAIL idle_nostart: v=%b fr=%0d, want 0 2", dout_valid, cnt_framing);
    end
    step(1'b1, 1'b1, 3'd4, 32'h0000_0001);
    step(1'b1, 1'b0, 3'd1, 32'h5200_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd4, 32'h9000_0000 + i);
    step(1'b1, 1'b0, 3'd2, 32'h9000_0003);
    nvec++;
    if (dout_valid !== 1'b1 || dout_end !== 1'b1 || cnt_framing !== 3'd3 || cnt_good !== 3'd1) begin
      nerr++;
      $display("FAIL payload_len: v=%b e=%b fr=%0d good=%0d, want 1 1 3 1",
               dout_valid, dout_end, cnt_framing, cnt_good);
    end
    step(1'b1, 1'b0, 3'd4, 32'h9000_0004);
    nvec++;
    if (dout_valid !== 1'b0 || cnt_framing !== 3'd4) begin
      nerr++;
      $display("FAIL after_abort: v=%b fr=%0d, want 0 4", dout_valid, cnt_framing);
    end
  endtask

  task automatic test_reset_midcell();
    do_reset();
    step(1'b1, 1'b1, 3'd4, 32'h0000_0000);
    step(1'b1, 1'b0, 3'd1, 32'h5500_0000);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 3'd4, 32'h7000_0000 + i);
    nvec++;
    if (cnt_good !== 3'd1) begin
      nerr++;
      $display("FAIL midcell_pre: good=%0d, want 1", cnt_good);
    end
    rst_n = 1'b0;
    step(1'b1, 1'b0, 3'd4, 32'h7000_0007);
    rst_n = 1'b1;
    nvec++;
    if (dout_valid !== 1'b0 || dout_end !== 1'b0 ||
        {cnt_good, cnt_corrected, cnt_bad, cnt_framing} !== 12'b0) begin
      nerr++;
      $display("FAIL midcell_reset: v=%b e=%b cnts=%h, want 0 0 000",
               dout_valid, dout_end, {cnt_good, cnt_corrected, cnt_bad, cnt_framing});
    end
    for (int i = 8; i < 12; i++) step(1'b1, 1'b0, 3'd4, 32'h7000_0000 + i);
    step(1'b1, 1'b1, 3'd4, 32'h0000_0001);
    step(1'b1, 1'b0, 3'd1, 32'h5200_0000);
    nvec++;
    if (dout_valid !== 1'b1 || dout_start !== 1'b1 || dout !== 32'h0000_0001 ||
        cnt_good !== 3'd1 || cnt_framing !== 3'd4) begin
      nerr++;
      $display("FAIL midcell_next: v=%b s=%b d=%h good=%0d fr=%0d, want 1 1 00000001 1 4",
               dout_valid, dout_start, dout, cnt_good, cnt_framing);
    end
  endtask

  task automatic test_gaps_saturation();
    logic [2:0] want;
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      step(1'b1, 1'b1, 3'd4, 32'h0000_0000);
      step(1'b0, 1'b0, 3'd0, '0);
      step(1'b1, 1'b0, 3'd1, 32'h5500_0000);
      nvec++;
      if (dout_valid !== 1'b1 || dout_start !== 1'b1 || dout !== 32'h0000_0000) begin
        nerr++;
        $display("FAIL gap_hdr[%0d]: v=%b s=%b d=%h, want 1 1 00000000", c, dout_valid, dout_start, dout);
      end
      for (int i = 0; i < 12; i++) begin
        step(1'b1, 1'b0, 3'd4, 32'h5000_0000 + c * 256 + i);
        nvec++;
        if (dout_valid !== 1'b1 || dout_end !== (i == 11) || dout !== 32'h5000_0000 + c * 256 + i) begin
          nerr++;
          $display("FAIL gap_payload[%0d][%0d]: v=%b e=%b d=%h, want 1 %b %h",
                   c, i, dout_valid, dout_end, dout, i == 11, 32'h5000_0000 + c * 256 + i);
        end
        if (i % 3 == 1) begin
          step(1'b0, 1'b0, 3'd4, 32'hDEAD_BEEF);
          nvec++;
          if (dout_valid !== 1'b0) begin
            nerr++;
            $display("FAIL gap_idle[%0d][%0d]: v=%b, want 0", c, i, dout_valid);
          end
        end
      end
      want = (c < 7) ? 3'(c) : 3'd7;
      nvec++;
      if (cnt_good !== want) begin
        nerr++;
        $display("FAIL sat_good[%0d]: good=%0d, want %0d", c, cnt_good, want);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din_start = 1'b0;
    din_len   = 3'd0;
    din       = '0;
    @(negedge clk);
    test_reset();
    test_good_cell();
    test_hec_error();
    test_bad_drop();
    test_framing_restart();
    test_framing_len();
    test_reset_midcell();
    test_gaps_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/atm_hec_checker.md
ATM_HEC_CHECKER -- requirements
Module: atm_hec_checker

Interface
REQ-001 Parameter DROP_BAD, default 1: uncorrectable cells are discarded, not forwarded.
REQ-002 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 din_valid  in  1  input beat valid.
REQ-006 din_start  in  1  first beat of a cell.
REQ-007 din_len  in  3  valid bytes in the beat, left aligned in din.
REQ-008 din  in  32  cell data, with the first byte in din[31:24].
REQ-009 dout_valid, dout_start, dout_end  out  1 each  output beat qualifiers.
REQ-010 dout  out  32  forwarded header or payload word.
REQ-011 hdr_ok, hdr_corrected  out  1 each  HEC status, valid on the dout_start beat.
REQ-012 cnt_good, cnt_corrected, cnt_bad, cnt_framing  out  CNT_WIDTH each  saturating statistics counters.

Function
REQ-013 The input framing SHALL be fixed: beat 0 is header bytes 0-3 (len 4, start=1); beat 1 is HEC in din[31:24] (len 1); beats 2-13 are 48 payload bytes (len 4 each).
REQ-014 The HEC SHALL be CRC-8 over the 4 header bytes, MSB first: poly x^8+x^2+x+1, init 0x00, no reflection, result XOR 0x55.
REQ-015 The FSM states SHALL be IDLE, WAIT_HEC, PAYLOAD and DISCARD.
REQ-016 IDLE: a valid beat with start=1 and len=4 SHALL register the header and go to WAIT_HEC; any other valid beat increments cnt_framing and is dropped.
REQ-017 WAIT_HEC: a valid beat with len=1 and start=0 SHALL be compared against the computed HEC; the syndrome is computed XOR received.
REQ-018 Syndrome 0: emit the header word with dout_start=1 and hdr_ok=1, increment cnt_good, go to PAYLOAD.
REQ-019 Nonzero syndrome that is not correctable: emit with hdr_ok=0, increment cnt_bad, then go to PAYLOAD if DROP_BAD=0, otherwise go to DISCARD and suppress the header output.
REQ-020 PAYLOAD: forward 12 beats with a 4-bit beat counter; the 12th beat SHALL carry dout_end=1 and return the FSM to IDLE.
REQ-021 DISCARD: consume 12 beats with no output, then return to IDLE.
REQ-022 Latency SHALL be 1 cycle from the input beat to dout.
REQ-023 The header SHALL be output on the cycle after the HEC beat; the HEC byte itself is never forwarded.
REQ-024 Framing error: din_start=1 in any state other than IDLE, or a wrong len in WAIT_HEC or payload.
REQ-025 On a framing error the cell SHALL be aborted: increment cnt_framing, assert dout_end=1 with dout_valid=1 if the cell was being forwarded, go to IDLE.
REQ-026 A start beat that causes an abort SHALL itself be re-evaluated as a new cell in the same cycle.
REQ-027 din_valid=0 SHALL hold state; gaps are allowed between any beats.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 When a cell's counter increment coincides with a framing increment, both counters SHALL update in that cycle.

Reset
REQ-030 With rst_n=0 at a clock edge: FSM to IDLE, beat counter 0, all counters 0.
REQ-031 During reset dout_valid, dout_start, dout_end, hdr_ok and hdr_corrected SHALL be 0 and dout SHALL be 0.
REQ-032 Reset asserted mid-cell SHALL abandon the cell with no dout_end and no counter update.

Configuration
REQ-033 With macro ATM_HEC_CORRECT_EN defined, a syndrome matching one of the 40 single-bit-error syndromes SHALL flip that bit.
REQ-034 With ATM_HEC_CORRECT_EN defined, if the flipped bit is in the header, the corrected header is emitted with hdr_ok=1 and hdr_corrected=1, and cnt_corrected increments.
REQ-035 With ATM_HEC_CORRECT_EN defined, if the flipped bit is in the HEC, the header is emitted unchanged with hdr_ok=1 and hdr_corrected=1.
REQ-036 Without ATM_HEC_CORRECT_EN, every nonzero syndrome SHALL be treated as bad, hdr_corrected SHALL be tied 0, and cnt_corrected SHALL stay 0.

Structure
REQ-037 Package atm_pkg SHALL hold the FSM state enum, HEC_COSET=8'h55, CELL_PAYLOAD_BEATS=12 and the function computing CRC-8 over 32 bits.
REQ-038 The sub-module atm_hec_syndrome_decode SHALL map an 8-bit syndrome to a one-hot 40-bit error position; it is instantiated only under ATM_HEC_CORRECT_EN.

Verification
REQ-039 Idle cell (header 32'h00000001, HEC 0x52, 12 payload beats) -> header out with hdr_ok=1, 12 payload beats, dout_end on the last beat, cnt_good=1.
REQ-040 Header 32'h00000000 with HEC 0x52 (syndrome 0x07), correction enabled -> dout 32'h00000001, hdr_corrected=1, cnt_corrected=1; without the macro, no output and cnt_bad=1.
REQ-041 Header 32'h00000000 with HEC 0xAA, DROP_BAD=1 -> no dout for the whole cell, cnt_bad=1, next good cell forwarded normally.
REQ-042 din_start=1 at payload beat 5 -> the previous cell is terminated with dout_end, cnt_framing=1, the new cell is processed correctly.
REQ-043 rst_n low for 1 cycle at payload beat 7, then a good cell -> no dout_end for the aborted cell, counters 0 then cnt_good=1.
REQ-044 Good cells with din_valid gaps, and cnt_good preloaded near saturation by forcing 2^CNT_WIDTH+3 cells -> output beats match the input, cnt_good holds at all-ones.
